// File: rtl/dual_edge_register.sv
// Double-data-rate capture register: samples data_i on both clk_i edges.
// Two XOR-coded banks let data_o follow the latest capture without a clock-driven mux.
module dual_edge_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] neg_q, neg_d;

  // Each bank stores data XOR the opposite bank, so pos_q ^ neg_q yields the value just captured.
  always_comb begin
    pos_d = pos_q;
    neg_d = neg_q;
    if (en_i) begin
      pos_d = data_i ^ neg_q;
      neg_d = data_i ^ pos_q;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  always_ff @(negedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      neg_q <= '0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign data_o = pos_q ^ neg_q;

endmodule

// File: tb/tb_dual_edge_register.sv
// Directed and random checks of dual_edge_register against a simple any-edge capture model.
module tb_dual_edge_register;

  localparam int W = 8;

  logic         clkI  = 1'b0;
  logic         arstN = 1'b1;
  logic         enI   = 1'b0;
  logic [W-1:0] dataI = '0;
  logic [W-1:0] dataO;

  logic [W-1:0] modelQ = '0;
  int errorCount = 0;
  int checkCount = 0;

  dual_edge_register #(.WIDTH(W)) dut (
    .clk_i  (clkI),
    .arst_ni(arstN),
    .en_i   (enI),
    .data_i (dataI),
    .data_o (dataO)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [W-1:0] data);
    enI   = en;
    dataI = data;
  endtask

  // Inputs settle 4 ns before the edge; the model captures pre-edge values, output is sampled 1 ns after.
  task automatic clockEdge();
    #4;
    if (arstN && enI) modelQ = dataI;
    clkI = ~clkI;
    #1;
  endtask

  task automatic setReset(input logic level);
    arstN = level;
    if (!level) modelQ = '0;
  endtask

  initial begin
    // Reset with the clock idle
    #1;
    applyStimulus(1'b1, 8'hFF);
    setReset(1'b0);
    #1;
    checkOutput("reset_idle", dataO, 8'h00);
    setReset(1'b1);
    #1;
    checkOutput("reset_release_no_edge", dataO, 8'h00);

    // Capture on a rising then a falling edge
    applyStimulus(1'b1, 8'hA5);
    clockEdge();
    checkOutput("rise_capture", dataO, 8'hA5);
    applyStimulus(1'b1, 8'h3C);
    clockEdge();
    checkOutput("fall_capture", dataO, 8'h3C);

    // Enable low holds across four edges
    applyStimulus(1'b0, 8'h77);
    for (int i = 0; i < 4; i++) begin
      clockEdge();
      checkOutput("hold", dataO, 8'h3C);
    end
    applyStimulus(1'b1, 8'h77);
    clockEdge();
    checkOutput("reenable_rise", dataO, 8'h77);
    applyStimulus(1'b1, 8'h12);
    clockEdge();
    checkOutput("reenable_fall", dataO, 8'h12);

    // Asynchronous reset between edges, edges ignored while held
    applyStimulus(1'b1, 8'h55);
    clockEdge();
    checkOutput("pre_reset_value", dataO, 8'h55);
    #2;
    setReset(1'b0);
    #1;
    checkOutput("async_clear", dataO, 8'h00);
    applyStimulus(1'b1, 8'hAA);
    for (int i = 0; i < 2; i++) begin
      clockEdge();
      checkOutput("edge_in_reset", dataO, 8'h00);
    end
    setReset(1'b1);
    applyStimulus(1'b1, 8'h99);
    clockEdge();
    checkOutput("post_reset_capture", dataO, 8'h99);
    applyStimulus(1'b1, 8'h66);
    clockEdge();
    checkOutput("post_reset_next_edge", dataO, 8'h66);

    // Random regression over 10000 edges with occasional reset pulses
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom));
      if (i % 997 == 500) begin
        setReset(1'b0);
        #1;
        checkOutput("rand_reset", dataO, modelQ);
        setReset(1'b1);
      end
      clockEdge();
      checkOutput("rand", dataO, modelQ);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
